// File: rtl/rpu_in_desc_feeder.sv
// Descriptor feeder for the RPU: small FIFO of inbound descriptors gated by a
// count of free packet slots, with flush, over-release detection and sync reset.
module rpu_in_desc_feeder #(
  parameter int DESC_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int SLOT_COUNT = 32,
  parameter int CNT_WIDTH  = $clog2(SLOT_COUNT + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DESC_WIDTH-1:0]             s_desc,
  input  logic                              s_desc_valid,
  output logic                              s_desc_ready,
  output logic [DESC_WIDTH-1:0]             in_desc,
  output logic                              in_desc_valid,
  input  logic                              in_desc_taken,
  input  logic                              slot_release,
  input  logic                              flush,
  output logic [CNT_WIDTH-1:0]              slots_free,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              release_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);

  logic [DESC_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [FC_W-1:0]       count_reg, count_next;
  logic [CNT_WIDTH-1:0]  slots_reg, slots_next;
  logic                  err_reg, err_next;

  logic        full;
  logic        ready_int;
  logic        accept;
  logic        pop;
  logic        release_ok;
  logic [31:0] slot_base;

  assign full      = (count_reg == FC_W'(FIFO_DEPTH));
  assign ready_int = !full && (slots_reg != '0) && !flush;
  assign accept    = s_desc_valid && ready_int && !rst;
  assign pop       = in_desc_taken && (count_reg != '0) && !flush;

  // Slots held by flushed descriptors come back this cycle; a release is only
  // honoured if it still fits under SLOT_COUNT after that return.
  always_comb begin
    slot_base = 32'(slots_reg) - 32'(accept);
    if (flush) begin
      slot_base = slot_base + 32'(count_reg);
    end
    release_ok = slot_release && (slot_base < 32'(SLOT_COUNT));
    slots_next = CNT_WIDTH'(slot_base + 32'(release_ok));
    err_next   = err_reg || (slot_release && !release_ok);
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = wr_ptr_reg;
      count_next  = '0;
    end else begin
      if (accept) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      count_next = count_reg + FC_W'(accept) - FC_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      slots_reg  <= CNT_WIDTH'(SLOT_COUNT);
      err_reg    <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      slots_reg  <= slots_next;
      err_reg    <= err_next;
    end
  end

  // Storage has no reset; only valid/count qualify its contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_reg] <= s_desc;
    end
  end

  assign in_desc       = mem[rd_ptr_reg];
  assign in_desc_valid = !rst && (count_reg != '0);
  assign s_desc_ready  = !rst && ready_int;
  assign fifo_count    = rst ? '0 : count_reg;
  assign slots_free    = rst ? CNT_WIDTH'(SLOT_COUNT) : slots_reg;
  assign release_err   = !rst && err_reg;

endmodule

// File: tb/tb_rpu_in_desc_feeder.sv
// Directed bench for rpu_in_desc_feeder with default parameters.
module tb_rpu_in_desc_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_desc;
  logic        s_desc_valid;
  logic        s_desc_ready;
  logic [63:0] in_desc;
  logic        in_desc_valid;
  logic        in_desc_taken;
  logic        slot_release;
  logic        flush;
  logic [5:0]  slots_free;
  logic [2:0]  fifo_count;
  logic        release_err;

  int checks   = 0;
  int failures = 0;

  rpu_in_desc_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .s_desc       (s_desc),
    .s_desc_valid (s_desc_valid),
    .s_desc_ready (s_desc_ready),
    .in_desc      (in_desc),
    .in_desc_valid(in_desc_valid),
    .in_desc_taken(in_desc_taken),
    .slot_release (slot_release),
    .flush        (flush),
    .slots_free   (slots_free),
    .fifo_count   (fifo_count),
    .release_err  (release_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-24s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; s_desc = '0; s_desc_valid = 0; in_desc_taken = 0;
    slot_release = 0; flush = 0;
    tick(); tick();
    chk("rst_ready", 64'(s_desc_ready), 64'd0);
    chk("rst_valid", 64'(in_desc_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_slots", 64'(slots_free), 64'd32);
    chk("rst_err", 64'(release_err), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 64'(s_desc_ready), 64'd1);

    // Over-release with all slots free
    slot_release = 1; tick(); slot_release = 0;
    chk("overrel_slots", 64'(slots_free), 64'd32);
    chk("overrel_err", 64'(release_err), 64'd1);

    // Single descriptor
    s_desc = 64'hA5; s_desc_valid = 1;
    chk("single_valid_pre", 64'(in_desc_valid), 64'd0);
    tick(); s_desc_valid = 0;
    chk("single_valid", 64'(in_desc_valid), 64'd1);
    chk("single_data", in_desc, 64'hA5);
    chk("single_slots", 64'(slots_free), 64'd31);
    in_desc_taken = 1; tick(); in_desc_taken = 0;
    chk("single_popped", 64'(in_desc_valid), 64'd0);
    chk("single_slots_post", 64'(slots_free), 64'd31);
    slot_release = 1; tick(); slot_release = 0;
    chk("single_release", 64'(slots_free), 64'd32);
    chk("err_sticky", 64'(release_err), 64'd1);

    // Fill buffer
    for (int i = 1; i <= 4; i++) begin
      s_desc = 64'(i); s_desc_valid = 1;
      chk($sformatf("fill_ready_%0d", i), 64'(s_desc_ready), 64'd1);
      tick();
    end
    chk("full_ready", 64'(s_desc_ready), 64'd0);
    chk("full_count", 64'(fifo_count), 64'd4);
    s_desc = 64'd5; tick(); s_desc_valid = 0;
    chk("full_count_hold", 64'(fifo_count), 64'd4);
    chk("full_slots", 64'(slots_free), 64'd28);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("pop_order_%0d", i), in_desc, 64'(i));
      in_desc_taken = 1; tick(); in_desc_taken = 0;
    end
    chk("drained_valid", 64'(in_desc_valid), 64'd0);
    slot_release = 1;
    repeat (4) tick();
    slot_release = 0;
    chk("refill_slots", 64'(slots_free), 64'd32);

    // Simultaneous accept and pop
    s_desc = 64'h10; s_desc_valid = 1; tick();
    s_desc = 64'h11; in_desc_taken = 1; tick();
    s_desc_valid = 0; in_desc_taken = 0;
    chk("simul_count", 64'(fifo_count), 64'd1);
    chk("simul_head", in_desc, 64'h11);
    chk("simul_slots", 64'(slots_free), 64'd30);
    in_desc_taken = 1; tick(); in_desc_taken = 0;
    slot_release = 1; repeat (2) tick(); slot_release = 0;
    chk("simul_restore", 64'(slots_free), 64'd32);

    // Slot exhaustion
    s_desc_valid = 1; in_desc_taken = 1;
    for (int i = 0; i < 32; i++) begin
      s_desc = 64'(i + 64'h100);
      tick();
    end
    chk("exh_slots", 64'(slots_free), 64'd0);
    chk("exh_ready", 64'(s_desc_ready), 64'd0);
    chk("exh_count", 64'(fifo_count), 64'd1);
    chk("exh_head", in_desc, 64'h11F);
    slot_release = 1; tick(); slot_release = 0;
    chk("exh_rel_slots", 64'(slots_free), 64'd1);
    chk("exh_rel_ready", 64'(s_desc_ready), 64'd1);
    chk("exh_rel_count", 64'(fifo_count), 64'd0);
    s_desc_valid = 0; in_desc_taken = 0;
    slot_release = 1; repeat (31) tick(); slot_release = 0;
    chk("exh_restore", 64'(slots_free), 64'd32);

    // Flush with concurrent release
    s_desc_valid = 1;
    for (int i = 0; i < 3; i++) begin
      s_desc = 64'(i + 64'h21);
      tick();
    end
    chk("pre_flush_count", 64'(fifo_count), 64'd3);
    chk("pre_flush_slots", 64'(slots_free), 64'd29);
    flush = 1; slot_release = 1; in_desc_taken = 1;
    #1;
    chk("flush_ready", 64'(s_desc_ready), 64'd0);
    tick();
    flush = 0; slot_release = 0; in_desc_taken = 0; s_desc_valid = 0;
    chk("flush_count", 64'(fifo_count), 64'd0);
    chk("flush_valid", 64'(in_desc_valid), 64'd0);
    chk("flush_slots", 64'(slots_free), 64'd32);

    // Reset mid-stream
    s_desc_valid = 1;
    s_desc = 64'h31; tick();
    s_desc = 64'h32; tick();
    s_desc_valid = 0;
    chk("pre_rst_count", 64'(fifo_count), 64'd2);
    rst = 1;
    #1;
    chk("rst_mid_valid_now", 64'(in_desc_valid), 64'd0);
    chk("rst_mid_ready_now", 64'(s_desc_ready), 64'd0);
    tick();
    chk("rst_mid_valid", 64'(in_desc_valid), 64'd0);
    chk("rst_mid_count", 64'(fifo_count), 64'd0);
    chk("rst_mid_slots", 64'(slots_free), 64'd32);
    chk("rst_mid_err", 64'(release_err), 64'd0);
    rst = 0;
    tick();
    chk("post_rst_valid", 64'(in_desc_valid), 64'd0);
    chk("post_rst_count", 64'(fifo_count), 64'd0);
    chk("post_rst_ready", 64'(s_desc_ready), 64'd1);
    chk("post_rst_err", 64'(release_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
